// File: rtl/mc_exec_core_if.sv
// Micro-op and data-memory bundle for mc_exec_core.
// Micro-op handshake: a micro-op transfers on a rising clk edge where
// op_valid and op_ready are both 1; the offering side keeps every op_* field
// stable while op_valid is 1 and op_ready is 0. Memory port: mem_req stays 1
// with mem_we/mem_addr/mem_wdata stable until the edge that samples
// mem_ack=1, which completes the access (mem_rdata valid on that edge).
interface mc_exec_core_if #(
  parameter int WIDTH = 32,
  parameter int NREG  = 16
);
  localparam int AW = $clog2(NREG);

  logic             op_valid;
  logic             op_ready;
  logic [3:0]       op_code;
  logic [AW-1:0]    op_rd;
  logic [AW-1:0]    op_rn;
  logic [AW-1:0]    op_rm;
  logic [WIDTH-1:0] op_imm;
  logic             op_use_imm;
  logic             op_set_flags;

  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ack;

  // Decoder plus data memory: offers micro-ops, answers memory requests.
  modport master (
    output op_valid, op_code, op_rd, op_rn, op_rm, op_imm, op_use_imm, op_set_flags,
    input  op_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

  // Execute core.
  modport slave (
    input  op_valid, op_code, op_rd, op_rn, op_rm, op_imm, op_use_imm, op_set_flags,
    output op_ready,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );
endinterface

// File: rtl/mc_exec_core.sv
// Multi-cycle execute core: register file, operand latches A/B/C, result
// latch F and NZCV flags. One micro-op at a time walks IDLE->READ->EXEC and
// then MEM (loads/stores) and/or WB before returning to IDLE.
module mc_exec_core #(
  parameter int WIDTH = 32,
  parameter int NREG  = 16
) (
  input  logic             clk,
  input  logic             rst,
  mc_exec_core_if.slave    bus,
  output logic [WIDTH-1:0] F,
  output logic [3:0]       nzcv,
  output logic             busy,
  output logic             und,
  output logic [2:0]       dbg_state_o
);
  localparam int AW = $clog2(NREG);
  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_ORR = 4'd3;
  localparam logic [3:0] OP_EOR = 4'd4;
  localparam logic [3:0] OP_MOV = 4'd5;
  localparam logic [3:0] OP_LSL = 4'd6;
  localparam logic [3:0] OP_LSR = 4'd7;
  localparam logic [3:0] OP_CMP = 4'd8;
  localparam logic [3:0] OP_LDR = 4'd9;
  localparam logic [3:0] OP_STR = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EXEC = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4
  } state_t;

  state_t           state_q;
  logic [3:0]       opc_q;
  logic [AW-1:0]    rd_q;
  logic [AW-1:0]    rn_q;
  logic [AW-1:0]    rm_q;
  logic [WIDTH-1:0] imm_q;
  logic             use_imm_q;
  logic             set_flags_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] c_q;
  logic [WIDTH-1:0] f_q;
  logic [3:0]       nzcv_q;
  logic             und_q;
  logic             mem_req_q;
  logic             mem_we_q;
  logic             ready_q;
  logic [WIDTH-1:0] regs_q [NREG];

  logic [WIDTH:0]   sum_d;
  logic [WIDTH:0]   diff_d;
  logic [WIDTH:0]   shl_d;
  logic [WIDTH:0]   shr_d;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] alu_f_d;
  logic             alu_c_d;
  logic             alu_v_d;
  logic             is_mem;
  logic             is_und;
  logic             upd_flags;

  assign shamt     = b_q[SW-1:0];
  assign is_mem    = (opc_q == OP_LDR) || (opc_q == OP_STR);
  assign is_und    = (opc_q > OP_STR);
  // CMP always sets flags; loads/stores never do.
  assign upd_flags = (set_flags_q || (opc_q == OP_CMP)) && !is_mem;

  // ALU on the latched operands; C/V default to their current values so
  // logic ops and zero-length shifts leave them untouched.
  always_comb begin
    sum_d   = {1'b0, a_q} + {1'b0, b_q};
    diff_d  = {1'b0, a_q} - {1'b0, b_q};
    // Extra bit above / below catches the last bit shifted out.
    shl_d   = {1'b0, a_q} << shamt;
    shr_d   = {a_q, 1'b0} >> shamt;
    alu_f_d = '0;
    alu_c_d = nzcv_q[1];
    alu_v_d = nzcv_q[0];
    case (opc_q)
      OP_ADD, OP_LDR, OP_STR: begin
        alu_f_d = sum_d[WIDTH-1:0];
        alu_c_d = sum_d[WIDTH];
        alu_v_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        alu_f_d = diff_d[WIDTH-1:0];
        alu_c_d = ~diff_d[WIDTH];
        alu_v_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: alu_f_d = a_q & b_q;
      OP_ORR: alu_f_d = a_q | b_q;
      OP_EOR: alu_f_d = a_q ^ b_q;
      OP_MOV: alu_f_d = b_q;
      OP_LSL: begin
        alu_f_d = shl_d[WIDTH-1:0];
        if (shamt != '0) alu_c_d = shl_d[WIDTH];
      end
      OP_LSR: begin
        alu_f_d = shr_d[WIDTH:1];
        if (shamt != '0) alu_c_d = shr_d[0];
      end
      default: alu_f_d = '0;
    endcase
  end

  // Control FSM with all datapath latches and the register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      opc_q       <= '0;
      rd_q        <= '0;
      rn_q        <= '0;
      rm_q        <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      set_flags_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      f_q         <= '0;
      nzcv_q      <= '0;
      und_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      ready_q     <= 1'b1;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      und_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.op_valid) begin
            opc_q       <= bus.op_code;
            rd_q        <= bus.op_rd;
            rn_q        <= bus.op_rn;
            rm_q        <= bus.op_rm;
            imm_q       <= bus.op_imm;
            use_imm_q   <= bus.op_use_imm;
            set_flags_q <= bus.op_set_flags;
            ready_q     <= 1'b0;
            state_q     <= S_READ;
          end
        end
        S_READ: begin
          a_q     <= regs_q[rn_q];
          b_q     <= use_imm_q ? imm_q : regs_q[rm_q];
          c_q     <= regs_q[rd_q];
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (is_und) begin
            und_q   <= 1'b1;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            f_q <= alu_f_d;
            if (upd_flags) nzcv_q <= {alu_f_d[WIDTH-1], (alu_f_d == '0), alu_c_d, alu_v_d};
            if (is_mem) begin
              mem_req_q <= 1'b1;
              mem_we_q  <= (opc_q == OP_STR);
              state_q   <= S_MEM;
            end else begin
              state_q <= S_WB;
            end
          end
        end
        S_MEM: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (opc_q == OP_LDR) begin
              f_q     <= bus.mem_rdata;
              state_q <= S_WB;
            end else begin
              ready_q <= 1'b1;
              state_q <= S_IDLE;
            end
          end
        end
        S_WB: begin
          if (opc_q != OP_CMP) regs_q[rd_q] <= f_q;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.op_ready  = ready_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = f_q;
  assign bus.mem_wdata = c_q;
  assign F             = f_q;
  assign nzcv          = nzcv_q;
  assign busy          = ~ready_q;
  assign und           = und_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_mc_exec_core.sv
// Bench for mc_exec_core: random micro-op stream against a reference model,
// a memory responder with wait states, and directed corner cases.
module tb_mc_exec_core;
  localparam int W  = 32;
  localparam int N  = 16;
  localparam int EW = W + 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mc_exec_core_if #(.WIDTH(W), .NREG(N)) bus ();
  logic [W-1:0] F;
  logic [3:0]   nzcv;
  logic         busy, und;
  logic [2:0]   dbg_state;

  mc_exec_core #(.WIDTH(W), .NREG(N)) dut (
    .clk(clk), .rst(rst), .bus(bus), .F(F), .nzcv(nzcv),
    .busy(busy), .und(und), .dbg_state_o(dbg_state)
  );

  mc_exec_core_if #(.WIDTH(8), .NREG(4)) bus8 ();
  logic [7:0] F8;
  logic [3:0] nzcv8;
  logic       busy8, und8;
  logic [2:0] dbg_state8;

  mc_exec_core #(.WIDTH(8), .NREG(4)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8), .F(F8), .nzcv(nzcv8),
    .busy(busy8), .und(und8), .dbg_state_o(dbg_state8)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [EW-1:0]  exp_q[$];    // {F, nzcv, und} at each op completion
  logic [2*W:0]   mexp_q[$];   // {we, addr, wdata} per memory request
  int             ack_delay = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_note(input string name);
    total++;
    bad++;
    $display("FAIL %s: got no event expected one (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] m_reg [N];
  logic [W-1:0] m_f;
  logic [3:0]   m_nzcv;
  logic [W-1:0] m_mem   [logic [W-1:0]];
  logic [W-1:0] env_mem [logic [W-1:0]];

  function automatic logic [W-1:0] dflt(input logic [W-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_reg[i] = '0;
    m_f    = '0;
    m_nzcv = '0;
  endtask

  // Computes the architectural effect of one micro-op and queues the
  // expected completion (and memory request). lat = cycles until ready.
  task automatic model_op(input logic [3:0] code, input int rd, input int rn, input int rm,
                          input logic [W-1:0] imm, input logic ui, input logic sf,
                          output int lat);
    logic [W-1:0] a, b, r, ad;
    logic         c, v, fl, undp;
    longint       ss;
    int           sh;
    a    = m_reg[rn];
    b    = ui ? imm : m_reg[rm];
    sh   = int'(b[4:0]);
    c    = m_nzcv[1];
    v    = m_nzcv[0];
    r    = m_f;
    fl   = sf || (code == 4'd8);
    lat  = 4;
    undp = 1'b0;
    case (code)
      4'd0: begin
        r  = a + b;
        c  = (longint'(a) + longint'(b)) > longint'(64'hFFFF_FFFF);
        ss = longint'($signed(a)) + longint'($signed(b));
        v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'd1, 4'd8: begin
        r  = a - b;
        c  = (a >= b);
        ss = longint'($signed(a)) - longint'($signed(b));
        v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = b;
      4'd6: begin
        r = a << sh;
        if (sh != 0) c = a[32 - sh];
      end
      4'd7: begin
        r = a >> sh;
        if (sh != 0) c = a[sh - 1];
      end
      4'd9: begin
        ad = a + b;
        r  = m_mem.exists(ad) ? m_mem[ad] : dflt(ad);
        mexp_q.push_back({1'b0, ad, {W{1'b0}}});
        fl  = 1'b0;
        lat = 5;
      end
      4'd10: begin
        ad = a + b;
        r  = ad;
        mexp_q.push_back({1'b1, ad, m_reg[rd]});
        m_mem[ad] = m_reg[rd];
        fl = 1'b0;
      end
      default: begin
        undp = 1'b1;
        fl   = 1'b0;
        lat  = 3;
      end
    endcase
    if (!undp) begin
      if (fl) m_nzcv = {r[31], (r == '0), c, v};
      if (code != 4'd8 && code != 4'd10) m_reg[rd] = r;
      m_f = r;
    end
    exp_q.push_back({m_f, m_nzcv, undp});
  endtask

  // ---------------- driver ----------------
  // Offers one micro-op, keeps op_valid high with junk fields while busy,
  // and checks the accept-to-ready latency.
  task automatic issue(input logic [3:0] code, input int rd, input int rn, input int rm,
                       input logic [W-1:0] imm, input logic ui, input logic sf,
                       input int d, output int acc_cyc);
    int lat, n, exp_lat;
    n = 0;
    while (!bus.op_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.op_ready) fail_note("ready_wait");
    ack_delay        = d;
    bus.op_valid     = 1'b1;
    bus.op_code      = code;
    bus.op_rd        = 4'(rd);
    bus.op_rn        = 4'(rn);
    bus.op_rm        = 4'(rm);
    bus.op_imm       = imm;
    bus.op_use_imm   = ui;
    bus.op_set_flags = sf;
    model_op(code, rd, rn, rm, imm, ui, sf, lat);
    exp_lat = lat + ((code == 4'd9 || code == 4'd10) ? d : 0);
    @(posedge clk);
    acc_cyc = cyc;
    #1;
    bus.op_code      = 4'($urandom_range(0, 15));
    bus.op_rd        = 4'($urandom);
    bus.op_rn        = 4'($urandom);
    bus.op_rm        = 4'($urandom);
    bus.op_imm       = $urandom;
    bus.op_use_imm   = 1'($urandom);
    bus.op_set_flags = 1'($urandom);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.op_ready && n < 200);
    bus.op_valid = 1'b0;
    check("latency", n, exp_lat);
  endtask

  task automatic drive8(input logic [3:0] code, input int rd, input int rn,
                        input logic [7:0] imm, input logic sf);
    int n;
    bus8.op_valid     = 1'b1;
    bus8.op_code      = code;
    bus8.op_rd        = 2'(rd);
    bus8.op_rn        = 2'(rn);
    bus8.op_rm        = 2'(0);
    bus8.op_imm       = imm;
    bus8.op_use_imm   = 1'b1;
    bus8.op_set_flags = sf;
    @(posedge clk);
    #1 bus8.op_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus8.op_ready && n < 50);
    check("w8_latency", n, 4);
  endtask

  // ---------------- memory responder ----------------
  initial begin : responder
    logic [2*W:0] e;
    logic         we;
    logic [W-1:0] ad, wd;
    logic         aborted;
    int           waits;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (rst && bus.mem_req) begin
        we = bus.mem_we;
        ad = bus.mem_addr;
        wd = bus.mem_wdata;
        if (mexp_q.size() == 0) begin
          fail_note("mem_unexpected_req");
        end else begin
          e = mexp_q.pop_front();
          check("mem_we", we, e[2*W]);
          check("mem_addr", ad, e[2*W-1:W]);
          if (e[2*W]) check("mem_wdata", wd, e[W-1:0]);
        end
        waits   = ack_delay;
        aborted = 1'b0;
        for (int i = 0; i < waits; i++) begin
          @(negedge clk);
          if (!rst) begin
            aborted = 1'b1;
            break;
          end
          check("mem_hold", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata},
                {1'b1, we, ad, wd});
        end
        if (!aborted) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = env_mem.exists(ad) ? env_mem[ad] : dflt(ad);
          if (we) env_mem[ad] = wd;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        // Stray acknowledge while no request is outstanding.
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = $urandom;
      end
    end
  end

  // ---------------- completion monitor ----------------
  initial begin : monitor
    logic         prev;
    logic [EW-1:0] e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev = 1'b1;
      end else begin
        if (bus.op_ready && !prev) begin
          if (exp_q.size() == 0) begin
            fail_note("unexpected_completion");
          end else begin
            e = exp_q.pop_front();
            check("F", F, e[EW-1:5]);
            check("nzcv", nzcv, e[4:1]);
            check("und", und, e[0]);
            check("busy", busy, 1'b0);
          end
        end
        prev = bus.op_ready;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int          t0, t1, tx, n, sel, rd, rn, rm, d;
    logic [3:0]  code, nz_before;
    logic [W-1:0] imm;
    logic        ui, sf;
    bus.op_valid = 1'b0;  bus.op_code = '0;  bus.op_rd = '0;  bus.op_rn = '0;
    bus.op_rm = '0;       bus.op_imm = '0;   bus.op_use_imm = 1'b0;
    bus.op_set_flags = 1'b0;
    bus8.op_valid = 1'b0; bus8.op_code = '0; bus8.op_rd = '0; bus8.op_rn = '0;
    bus8.op_rm = '0;      bus8.op_imm = '0;  bus8.op_use_imm = 1'b0;
    bus8.op_set_flags = 1'b0;
    bus8.mem_ack = 1'b0;  bus8.mem_rdata = '0;
    model_reset();

    repeat (3) @(negedge clk);
    check("rst_ready", bus.op_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_F", F, 0);
    check("rst_nzcv", nzcv, 0);
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_und", und, 1'b0);
    check("rst_state", dbg_state, 3'd0);
    rst = 1'b1;
    @(negedge clk);

    // Signed overflow on ADD, then back-to-back acceptance spacing.
    issue(4'd5, 1, 0, 0, 32'h7FFF_FFFF, 1'b1, 1'b0, 0, tx);
    issue(4'd0, 2, 1, 0, 32'h1, 1'b1, 1'b1, 0, t0);
    check("add_ovf_F", F, 32'h8000_0000);
    check("add_ovf_nzcv", nzcv, 4'b1001);
    issue(4'd5, 0, 0, 0, 32'h0, 1'b1, 1'b0, 0, t1);
    check("b2b_spacing", t1 - t0, 4);

    // CMP equal, then register untouched; SUB with borrow.
    issue(4'd5, 1, 0, 0, 32'd5, 1'b1, 1'b0, 0, tx);
    issue(4'd8, 3, 1, 1, 32'h0, 1'b0, 1'b0, 0, tx);
    check("cmp_nzcv", nzcv, 4'b0110);
    issue(4'd5, 12, 0, 3, 32'h0, 1'b0, 1'b0, 0, tx);
    check("cmp_no_write", F, 32'h0);
    issue(4'd5, 4, 0, 0, 32'd3, 1'b1, 1'b0, 0, tx);
    issue(4'd1, 5, 4, 0, 32'd5, 1'b1, 1'b1, 0, tx);
    check("sub_F", F, 32'hFFFF_FFFE);
    check("sub_nzcv", nzcv, 4'b1000);

    // Shift carry, and zero-length shift keeps C.
    issue(4'd5, 6, 0, 0, 32'h8000_0001, 1'b1, 1'b0, 0, tx);
    issue(4'd6, 7, 6, 0, 32'd1, 1'b1, 1'b1, 0, tx);
    check("lsl_F", F, 32'h2);
    check("lsl_C", nzcv[1], 1'b1);
    issue(4'd7, 8, 7, 0, 32'd0, 1'b1, 1'b1, 0, tx);
    check("lsr0_F", F, 32'h2);
    check("lsr0_C", nzcv[1], 1'b1);

    // Store then load at 0x40 with three wait states each.
    issue(4'd5, 9, 0, 0, 32'h40, 1'b1, 1'b0, 0, tx);
    issue(4'd5, 10, 0, 0, 32'hCAFE_F00D, 1'b1, 1'b0, 0, tx);
    issue(4'd10, 10, 9, 0, 32'h0, 1'b1, 1'b0, 3, tx);
    check("str_F_addr", F, 32'h40);
    issue(4'd9, 11, 9, 0, 32'h0, 1'b1, 1'b0, 3, tx);
    check("ldr_F", F, 32'hCAFE_F00D);
    issue(4'd5, 12, 0, 11, 32'h0, 1'b0, 1'b0, 0, tx);
    check("ldr_reg", F, 32'hCAFE_F00D);

    // Undefined op: one-cycle pulse, no state change.
    nz_before = nzcv;
    issue(4'd12, 12, 1, 2, 32'h1234, 1'b1, 1'b1, 0, tx);
    check("und_high", und, 1'b1);
    check("und_F", F, 32'hCAFE_F00D);
    check("und_nzcv", nzcv, nz_before);
    @(negedge clk);
    check("und_low", und, 1'b0);

    // Seed registers, then a random micro-op stream.
    for (int i = 0; i < N; i++) issue(4'd5, i, 0, 0, $urandom, 1'b1, 1'b0, 0, tx);
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 19);
      if (sel <= 10)      code = 4'(sel);
      else if (sel < 17)  code = 4'($urandom_range(0, 10));
      else                code = 4'($urandom_range(11, 15));
      case ($urandom_range(0, 4))
        0:       imm = W'($urandom_range(0, 40));
        1:       imm = 32'h7FFF_FFFF;
        2:       imm = 32'h8000_0000;
        3:       imm = 32'hFFFF_FFFF;
        default: imm = $urandom;
      endcase
      rd = $urandom_range(0, N - 1);
      rn = $urandom_range(0, N - 1);
      rm = $urandom_range(0, N - 1);
      ui = 1'($urandom);
      sf = 1'($urandom);
      d  = $urandom_range(0, 3);
      issue(code, rd, rn, rm, imm, ui, sf, d, tx);
    end

    // Reset while a load is waiting for its acknowledge.
    ack_delay = 20;
    mexp_q.push_back({1'b0, m_reg[9], {W{1'b0}}});
    bus.op_valid = 1'b1;  bus.op_code = 4'd9;  bus.op_rd = 4'd1;  bus.op_rn = 4'd9;
    bus.op_rm = 4'd0;     bus.op_imm = '0;     bus.op_use_imm = 1'b1;
    bus.op_set_flags = 1'b1;
    @(posedge clk);
    #1 bus.op_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.mem_req && n < 20);
    check("rst_test_req_seen", bus.mem_req, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("midrst_mem_req", bus.mem_req, 1'b0);
    check("midrst_mem_we", bus.mem_we, 1'b0);
    check("midrst_F", F, 0);
    check("midrst_nzcv", nzcv, 0);
    check("midrst_ready", bus.op_ready, 1'b1);
    check("midrst_state", dbg_state, 3'd0);
    exp_q.delete();
    mexp_q.delete();
    model_reset();
    @(negedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    check("postrst_ready", bus.op_ready, 1'b1);
    for (int i = 0; i < N; i++) begin
      issue(4'd5, i, 0, i, 32'h0, 1'b0, 1'b0, 0, tx);
      check("reg_cleared", F, 0);
    end

    // Narrow configuration: 8-bit wraparound.
    @(negedge clk);
    check("w8_rst_F", F8, 8'h00);
    check("w8_ready", bus8.op_ready, 1'b1);
    drive8(4'd5, 1, 0, 8'hFF, 1'b0);
    check("w8_mov_F", F8, 8'hFF);
    drive8(4'd0, 2, 1, 8'h01, 1'b1);
    check("w8_add_F", F8, 8'h00);
    check("w8_add_nzcv", nzcv8, 4'b0110);

    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    fail_note("watchdog");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
